// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream (in_*) and downstream (out_*) sides.
// master is the surrounding pipeline's view; slave is the stage register itself.
interface pipe_stage_reg_if #(
    parameter int PC_W   = 13,
    parameter int DATA_W = 69,
    parameter int CTRL_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_pc, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_pc, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_pc, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_pc, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, stall, flush-to-bubble and an optional
// 2-entry skid buffer (SKID=1) whose in_ready depends only on held state, not on out_ready.
module pipe_stage_reg #(
    parameter int PC_W   = 13,
    parameter int DATA_W = 69,
    parameter int CTRL_W = 6,
    parameter int SKID   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       count,
    output logic [15:0]      bubble_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t head_reg;
    entry_t skid_reg;
    entry_t in_entry;
    logic   head_valid_reg;
    logic   skid_valid_reg;
    logic   [15:0] bubble_reg;

    logic   room;
    logic   push;
    logic   pop;

    assign in_entry = {bus.in_pc, bus.in_data, bus.in_ctrl};

    // Stall gates the release internally so a held entry is never consumed while frozen.
    assign pop = head_valid_reg & bus.out_ready & ~stall;

    generate
        if (SKID == 0) begin : g_single
            assign room = ~head_valid_reg | bus.out_ready;
        end else begin : g_skid
            assign room = ~skid_valid_reg;
        end
    endgenerate

    assign bus.in_ready = ~rst & ~stall & ~flush & room;
    assign push         = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg       <= '0;
            skid_reg       <= '0;
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            head_reg.ctrl  <= '0;
            skid_reg.ctrl  <= '0;
        end else if (skid_valid_reg) begin
            // Full: nothing can be accepted, a release promotes the skid entry.
            if (pop) begin
                head_reg       <= skid_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (head_valid_reg) begin
            if (pop && push) begin
                head_reg <= in_entry;
            end else if (pop) begin
                head_valid_reg <= 1'b0;
            end else if (push && (SKID != 0)) begin
                skid_reg       <= in_entry;
                skid_valid_reg <= 1'b1;
            end
        end else if (push) begin
            head_reg       <= in_entry;
            head_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_reg <= '0;
        end else if (!head_valid_reg && (bubble_reg != 16'hFFFF)) begin
            bubble_reg <= bubble_reg + 16'd1;
        end
    end

    assign bus.out_valid = head_valid_reg;
    assign bus.out_pc    = head_reg.pc;
    assign bus.out_data  = head_reg.data;
    assign bus.out_ctrl  = head_valid_reg ? head_reg.ctrl : '0;
    assign count         = {skid_valid_reg, head_valid_reg & ~skid_valid_reg};
    assign bubble_cnt    = bubble_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a single-register and a skid-buffer instance with shared stimulus and checks both
// against queue-based reference models.
module tb_pipe_stage_reg;

    localparam int PC_W   = 13;
    localparam int DATA_W = 69;
    localparam int CTRL_W = 6;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    logic clk = 1'b0;
    logic rst, stall, flush, in_valid, out_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [1:0]  cnt0, cnt1;
    logic [15:0] bcnt0, bcnt1;

    int checks = 0;
    int failures = 0;

    ent_t q0[$];
    ent_t q1[$];
    int   bub0, bub1;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus0 ();
    pipe_stage_reg_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_pc     = in_pc;
    assign bus0.in_data   = in_data;
    assign bus0.in_ctrl   = in_ctrl;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_pc     = in_pc;
    assign bus1.in_data   = in_data;
    assign bus1.in_ctrl   = in_ctrl;
    assign bus1.out_ready = out_ready;

    pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus0), .count(cnt0), .bubble_cnt(bcnt0)
    );

    pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bus(bus1), .count(cnt1), .bubble_cnt(bcnt1)
    );

    // Reference: capacity-1 stage may take a new item only if it is empty or its item leaves now;
    // capacity-2 stage may take one whenever fewer than two are held.
    function automatic bit model_ready0();
        return !rst && !stall && !flush && (q0.size() == 0 || out_ready);
    endfunction

    function automatic bit model_ready1();
        return !rst && !stall && !flush && (q1.size() < 2);
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    task automatic tick();
        bit   r0, r1;
        ent_t e;
        r0 = model_ready0();
        r1 = model_ready1();
        e  = '{pc: in_pc, data: in_data, ctrl: in_ctrl};
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); bub0 = 0; bub1 = 0;
        end else begin
            if (q0.size() == 0 && bub0 < 65535) bub0++;
            if (q1.size() == 0 && bub1 < 65535) bub1++;
            if (flush) begin
                q0.delete(); q1.delete();
            end else begin
                if (q0.size() > 0 && out_ready && !stall) void'(q0.pop_front());
                if (q1.size() > 0 && out_ready && !stall) void'(q1.pop_front());
                if (in_valid && r0) q0.push_back(e);
                if (in_valid && r1) q1.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; flush = 0; in_valid = 1; out_ready = 1;
        in_pc = 13'h1FF; in_data = rand_data(); in_ctrl = 6'h3F;
        repeat (3) tick();
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%b/%b exp=0", bus0.out_valid, bus1.out_valid); end
        checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin failures++;
            $display("FAIL reset_count got=%0d/%0d exp=0", cnt0, cnt1); end
        checks++; if (bus0.out_pc !== '0 || bus1.out_pc !== '0 || bus0.out_data !== '0 || bus1.out_data !== '0) begin failures++;
            $display("FAIL reset_pc_data got=%h/%h exp=0", bus0.out_pc, bus1.out_pc); end
        checks++; if (bus0.out_ctrl !== '0 || bus1.out_ctrl !== '0) begin failures++;
            $display("FAIL reset_ctrl got=%h/%h exp=0", bus0.out_ctrl, bus1.out_ctrl); end
        checks++; if (bcnt0 !== 16'd0 || bcnt1 !== 16'd0) begin failures++;
            $display("FAIL reset_bubble got=%0d/%0d exp=0", bcnt0, bcnt1); end
        checks++; if (bus0.in_ready !== 1'b0 || bus1.in_ready !== 1'b0) begin failures++;
            $display("FAIL reset_in_ready got=%b/%b exp=0", bus0.in_ready, bus1.in_ready); end
        in_valid = 0;
        rst = 1'b0;
        #1;
        checks++; if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_release_ready got=%b/%b exp=1", bus0.in_ready, bus1.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1; in_pc = 13'(4 * k); in_data = rand_data(); in_ctrl = 6'($urandom());
            tick();
            checks++; if (bus0.out_pc !== 13'(4 * k) || bus0.out_valid !== 1'b1 || cnt0 !== 2'd1) begin failures++;
                $display("FAIL stream0 k=%0d got pc=%h v=%b cnt=%0d exp pc=%h v=1 cnt=1", k, bus0.out_pc, bus0.out_valid, cnt0, 13'(4 * k)); end
            checks++; if (bus1.out_pc !== 13'(4 * k) || bus1.out_valid !== 1'b1 || cnt1 !== 2'd1) begin failures++;
                $display("FAIL stream1 k=%0d got pc=%h v=%b cnt=%0d exp pc=%h v=1 cnt=1", k, bus1.out_pc, bus1.out_valid, cnt1, 13'(4 * k)); end
            $display("stream pc=%h out0=%h out1=%h", in_pc, bus0.out_pc, bus1.out_pc);
        end
        in_valid = 0;
        tick();
        checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || cnt0 !== 2'd0 || cnt1 !== 2'd0) begin failures++;
            $display("FAIL stream_drain got v=%b/%b cnt=%0d/%0d exp 0", bus0.out_valid, bus1.out_valid, cnt0, cnt1); end
    endtask

    task automatic test_stall();
        out_ready = 0; in_valid = 1; in_pc = 13'h010; in_data = rand_data(); in_ctrl = 6'h02;
        tick();
        stall = 1; out_ready = 1; in_pc = 13'h014; in_data = rand_data();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus0.in_ready !== 1'b0 || bus1.in_ready !== 1'b0) begin failures++;
                $display("FAIL stall_ready c=%0d got=%b/%b exp=0", c, bus0.in_ready, bus1.in_ready); end
            tick();
            checks++; if (bus0.out_pc !== 13'h010 || bus1.out_pc !== 13'h010 || bus0.out_valid !== 1'b1 || bus1.out_valid !== 1'b1) begin failures++;
                $display("FAIL stall_hold c=%0d got=%h/%h exp=010", c, bus0.out_pc, bus1.out_pc); end
            $display("stall cycle %0d out0=%h out1=%h", c, bus0.out_pc, bus1.out_pc);
        end
        stall = 0;
        #1;
        checks++; if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin failures++;
            $display("FAIL unstall_ready got=%b/%b exp=1", bus0.in_ready, bus1.in_ready); end
        tick();
        checks++; if (bus0.out_pc !== 13'h014 || bus1.out_pc !== 13'h014 || cnt0 !== 2'd1 || cnt1 !== 2'd1) begin failures++;
            $display("FAIL unstall_next got=%h/%h cnt=%0d/%0d exp=014 cnt=1", bus0.out_pc, bus1.out_pc, cnt0, cnt1); end
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_pc = 13'h030; in_data = rand_data(); in_ctrl = 6'b000001;
        tick();
        checks++; if (bus0.out_ctrl !== 6'b000001 || bus1.out_ctrl !== 6'b000001) begin failures++;
            $display("FAIL flush_pre_ctrl got=%b/%b exp=000001", bus0.out_ctrl, bus1.out_ctrl); end
        flush = 1; in_pc = 13'h034; in_data = rand_data();
        #1;
        checks++; if (bus0.in_ready !== 1'b0 || bus1.in_ready !== 1'b0) begin failures++;
            $display("FAIL flush_ready got=%b/%b exp=0", bus0.in_ready, bus1.in_ready); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus0.out_ctrl !== '0 || bus1.out_ctrl !== '0
                      || cnt0 !== 2'd0 || cnt1 !== 2'd0) begin failures++;
            $display("FAIL flush_result got v=%b/%b ctrl=%b/%b cnt=%0d/%0d exp all 0",
                     bus0.out_valid, bus1.out_valid, bus0.out_ctrl, bus1.out_ctrl, cnt0, cnt1); end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin failures++;
                $display("FAIL flush_dropped c=%0d got v=%b/%b pc=%h/%h exp v=0", c, bus0.out_valid, bus1.out_valid, bus0.out_pc, bus1.out_pc); end
        end
        $display("flush done v=%b/%b", bus0.out_valid, bus1.out_valid);
    endtask

    task automatic test_skid_fill();
        out_ready = 0; in_valid = 1; in_pc = 13'h020; in_data = rand_data(); in_ctrl = 6'h04;
        tick();
        in_pc = 13'h024; in_data = rand_data();
        tick();
        in_valid = 0;
        #1;
        checks++; if (cnt1 !== 2'd2 || bus1.in_ready !== 1'b0) begin failures++;
            $display("FAIL skid_full got cnt=%0d rdy=%b exp cnt=2 rdy=0", cnt1, bus1.in_ready); end
        checks++; if (cnt0 !== 2'd1 || bus0.out_pc !== 13'h020) begin failures++;
            $display("FAIL single_full got cnt=%0d pc=%h exp cnt=1 pc=020", cnt0, bus0.out_pc); end
        out_ready = 1;
        checks++; if (bus1.out_pc !== 13'h020) begin failures++;
            $display("FAIL skid_first got=%h exp=020", bus1.out_pc); end
        tick();
        checks++; if (bus1.out_pc !== 13'h024 || bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b1) begin failures++;
            $display("FAIL skid_second got pc=%h v=%b rdy=%b exp pc=024 v=1 rdy=1", bus1.out_pc, bus1.out_valid, bus1.in_ready); end
        tick();
        checks++; if (bus1.out_valid !== 1'b0 || bus0.out_valid !== 1'b0) begin failures++;
            $display("FAIL skid_empty got v=%b/%b exp 0", bus0.out_valid, bus1.out_valid); end
        $display("skid fill done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_pc     = 13'($urandom());
            in_data   = rand_data();
            in_ctrl   = 6'($urandom());
            #1;
            checks++; if (bus0.in_ready !== model_ready0() || bus1.in_ready !== model_ready1()) begin failures++;
                $display("FAIL rand_ready i=%0d got=%b/%b exp=%b/%b", i, bus0.in_ready, bus1.in_ready, model_ready0(), model_ready1()); end
            tick();
            checks++; if (bus0.out_valid !== (q0.size() > 0) || cnt0 !== 2'(q0.size()) || bcnt0 !== 16'(bub0)) begin failures++;
                $display("FAIL rand_state0 i=%0d got v=%b cnt=%0d bub=%0d exp v=%b cnt=%0d bub=%0d",
                         i, bus0.out_valid, cnt0, bcnt0, q0.size() > 0, q0.size(), bub0); end
            checks++; if (bus1.out_valid !== (q1.size() > 0) || cnt1 !== 2'(q1.size()) || bcnt1 !== 16'(bub1)) begin failures++;
                $display("FAIL rand_state1 i=%0d got v=%b cnt=%0d bub=%0d exp v=%b cnt=%0d bub=%0d",
                         i, bus1.out_valid, cnt1, bcnt1, q1.size() > 0, q1.size(), bub1); end
            if (q0.size() > 0) begin
                checks++; if (bus0.out_pc !== q0[0].pc || bus0.out_data !== q0[0].data || bus0.out_ctrl !== q0[0].ctrl) begin failures++;
                    $display("FAIL rand_head0 i=%0d got pc=%h ctrl=%h exp pc=%h ctrl=%h", i, bus0.out_pc, bus0.out_ctrl, q0[0].pc, q0[0].ctrl); end
            end else begin
                checks++; if (bus0.out_ctrl !== '0) begin failures++;
                    $display("FAIL rand_bubble0 i=%0d got ctrl=%h exp=0", i, bus0.out_ctrl); end
            end
            if (q1.size() > 0) begin
                checks++; if (bus1.out_pc !== q1[0].pc || bus1.out_data !== q1[0].data || bus1.out_ctrl !== q1[0].ctrl) begin failures++;
                    $display("FAIL rand_head1 i=%0d got pc=%h ctrl=%h exp pc=%h ctrl=%h", i, bus1.out_pc, bus1.out_ctrl, q1[0].pc, q1[0].ctrl); end
            end else begin
                checks++; if (bus1.out_ctrl !== '0) begin failures++;
                    $display("FAIL rand_bubble1 i=%0d got ctrl=%h exp=0", i, bus1.out_ctrl); end
            end
            $display("rand %0d in v=%b pc=%h st=%b fl=%b or=%b -> cnt=%0d/%0d", i, in_valid, in_pc, stall, flush, out_ready, cnt0, cnt1);
        end
        in_valid = 0; stall = 0; flush = 0; out_ready = 1;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1; in_pc = 13'h040; in_data = rand_data(); in_ctrl = 6'b000111;
        tick();
        in_pc = 13'h044; in_data = rand_data();
        tick();
        in_valid = 0;
        checks++; if (cnt1 !== 2'd2) begin failures++;
            $display("FAIL areset_pre got cnt=%0d exp=2", cnt1); end
        #2 rst = 1'b1;
        #1;
        q0.delete(); q1.delete(); bub0 = 0; bub1 = 0;
        checks++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || cnt0 !== 2'd0 || cnt1 !== 2'd0) begin failures++;
            $display("FAIL areset_state got v=%b/%b cnt=%0d/%0d exp 0", bus0.out_valid, bus1.out_valid, cnt0, cnt1); end
        checks++; if (bus0.out_ctrl !== '0 || bus1.out_ctrl !== '0 || bcnt0 !== 16'd0 || bcnt1 !== 16'd0) begin failures++;
            $display("FAIL areset_ctrl_bub got ctrl=%h/%h bub=%0d/%0d exp 0", bus0.out_ctrl, bus1.out_ctrl, bcnt0, bcnt1); end
        checks++; if (bus0.in_ready !== 1'b0 || bus1.in_ready !== 1'b0) begin failures++;
            $display("FAIL areset_ready got=%b/%b exp=0", bus0.in_ready, bus1.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus1.in_ready !== 1'b1) begin failures++;
            $display("FAIL areset_release got=%b exp=1", bus1.in_ready); end
        $display("async reset done");
    endtask

    task automatic test_bubble_sat();
        in_valid = 0; out_ready = 1; stall = 0; flush = 0;
        repeat (70000) tick();
        checks++; if (bcnt0 !== 16'hFFFF || bcnt1 !== 16'hFFFF) begin failures++;
            $display("FAIL bubble_sat got=%h/%h exp=ffff", bcnt0, bcnt1); end
        flush = 1;
        tick();
        flush = 0;
        tick();
        checks++; if (bcnt0 !== 16'hFFFF || bcnt1 !== 16'hFFFF) begin failures++;
            $display("FAIL bubble_flush got=%h/%h exp=ffff", bcnt0, bcnt1); end
        $display("bubble sat %h/%h", bcnt0, bcnt1);
    endtask

    initial begin
        bub0 = 0; bub1 = 0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_skid_fill();
        test_random();
        test_async_reset();
        test_bubble_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
